// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, bounded grant tenure and
// back-to-back handover between requesters.
module rr_onehot_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 expired
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            expired_q, expired_d;

  logic            found;
  logic            at_limit;
  logic [IW-1:0]   win;
  logic [IW-1:0]   start;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(N-1)) ? '0 : i + IW'(1);
  endfunction

  // First set bit of mask, scanning upward from start and wrapping at N-1.
  function automatic logic [IW-1:0] search(input logic [N-1:0] mask,
                                           input logic [IW-1:0] from,
                                           output logic hit);
    logic [IW-1:0] res;
    int j;
    hit = 1'b0;
    res = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(from) + i;
      if (j >= N) j = j - N;
      if (!hit && mask[j[IW-1:0]]) begin
        hit = 1'b1;
        res = j[IW-1:0];
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    expired_d = 1'b0;
    found     = 1'b0;
    at_limit  = 1'b0;
    win       = '0;
    start     = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win     = search(req, ptr_q, found);
          gnt_d   = onehot(win);
          idx_d   = win;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        at_limit = (hold_q == HW'(MAX_HOLD - 1));
        if (req[idx_q] && !at_limit) begin
          hold_d = hold_q + HW'(1);
        end else begin
          // The departing owner is masked out so an expiring owner never regrants itself.
          expired_d = req[idx_q];
          start     = next_idx(idx_q);
          ptr_d     = start;
          win       = search(req & ~onehot(idx_q), start, found);
          hold_d    = '0;
          if (found) begin
            gnt_d = onehot(win);
            idx_d = win;
          end else begin
            gnt_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      expired_q <= expired_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = idx_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Randomized and directed bench for rr_onehot_arbiter against a tenure-counting
// reference model.
module tb_rr_onehot_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IW       = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic          expired;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: owner is -1 when nothing is granted; tenure counts cycles held.
  int m_owner = -1;
  int m_ten   = 0;
  int m_ptr   = 0;
  bit m_exp   = 1'b0;

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .expired   (expired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] m, input int s);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (s + k) % N;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ten   = 0;
    m_ptr   = 0;
    m_exp   = 1'b0;
  endtask

  task automatic model_update(input logic [N-1:0] r);
    logic [N-1:0] others;
    m_exp = 1'b0;
    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner = first_from(r, m_ptr);
        m_ten   = 1;
      end
    end else if (r[m_owner] && m_ten < MAX_HOLD) begin
      m_ten++;
    end else begin
      m_exp           = r[m_owner];
      m_ptr           = (m_owner + 1) % N;
      others          = r;
      others[m_owner] = 1'b0;
      m_owner         = first_from(others, m_ptr);
      m_ten           = (m_owner < 0) ? 0 : 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, ".gnt"},     32'(gnt),       32'(eg));
    chk({tag, ".valid"},   32'(gnt_valid), 32'(m_owner >= 0));
    chk({tag, ".idx"},     32'(gnt_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk({tag, ".expired"}, 32'(expired),   32'(m_exp));
    chk({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
  endtask

  // Called at a negedge: drive req, let one edge pass, compare at the next negedge.
  task automatic step(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_update(r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] r;

    // 1: reset with all requesters active, then first grant from ptr=0.
    rst = 1'b1;
    req = '1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst.gnt",   32'(gnt),       32'd0);
      chk("rst.valid", 32'(gnt_valid), 32'd0);
      chk("rst.idx",   32'(gnt_idx),   32'd0);
    end
    rst = 1'b0;
    step(4'b1111, "t1");
    chk("t1.first", 32'(gnt), 32'b0001);

    // 2: single requester then drop; the following IDLE search must start at 3.
    do_reset();
    repeat (3) step(4'b0100, "t2");
    step(4'b0000, "t2.drop");
    step(4'b1111, "t2.ptr");
    chk("t2.ptr3", 32'(gnt), 32'b1000);

    // 3: everyone requesting, rotation on expiry.
    do_reset();
    repeat (40) step(4'b1111, "t3");

    // 4: owner drops while another requester waits.
    do_reset();
    step(4'b0010, "t4.own1");
    step(4'b1010, "t4.hold");
    step(4'b1000, "t4.hand");
    chk("t4.hand_gnt", 32'(gnt),     32'b1000);
    chk("t4.hand_exp", 32'(expired), 32'd0);
    step(4'b0000, "t4.idle");

    // 5: sole requester repeatedly expiring.
    do_reset();
    repeat (20) step(4'b0001, "t5");

    // 6: asynchronous reset in the middle of a grant.
    do_reset();
    repeat (6) step(4'b0100, "t6");
    rst = 1'b1;
    #1;
    chk("t6.async_gnt",   32'(gnt),       32'd0);
    chk("t6.async_valid", 32'(gnt_valid), 32'd0);
    chk("t6.async_idx",   32'(gnt_idx),   32'd0);
    rst = 1'b0;
    model_reset();
    step(4'b0100, "t6.after");
    chk("t6.regrant", 32'(gnt), 32'b0100);

    // Random run with sticky requests so long tenures occur.
    do_reset();
    r = N'($urandom);
    repeat (250) begin
      if ($urandom_range(3) == 0) r = N'($urandom);
      step(r, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
